// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_pkg                                                           |
// | Shared constants and types for the pipelined core datapath.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package core_pkg;

  typedef enum logic [1:0] {
    SFT_LSR = 2'b00,
    SFT_LSL = 2'b01,
    SFT_ASR = 2'b10,
    SFT_ROR = 2'b11
  } sft_op_e;

  // Bit positions inside the 4-bit NZCV flag word.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  localparam int DEF_DW    = 32;
  localparam int DEF_NREGS = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/wb_regfile_param_opr2_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | opr2_shifter                                                       |
// | Combinational LSR/LSL/ASR/ROR barrel shifter for operand 2.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module opr2_shifter
  import core_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AMT_W = 5
) (
  input  logic [DW-1:0]    value,
  input  logic [AMT_W-1:0] amt,
  input  sft_op_e          op,
  output logic [DW-1:0]    result
);

  localparam int c_RW = $clog2(DW);

  logic [c_RW-1:0] w_rot;
  logic [DW-1:0]   w_ror;

  // Rotation wraps modulo DW; a left shift by DW yields zero when w_rot is 0.
  assign w_rot = amt[c_RW-1:0];
  assign w_ror = (value >> w_rot) | (value << (DW - int'(w_rot)));

  always_comb begin
    result = value;
    unique case (op)
      SFT_LSR: result = value >> amt;
      SFT_LSL: result = value << amt;
      SFT_ASR: result = $signed(value) >>> amt;
      SFT_ROR: result = w_ror;
      default: result = value;
    endcase
  end

endmodule : opr2_shifter
`default_nettype wire

// File: rtl/wb_regfile_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_regfile_param                                                   |
// | Write-back register file, operand fetch with bypass, NZCV, debug.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module wb_regfile_param
  import core_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int NREGS       = DEF_NREGS,
  parameter int SHOW_W      = 16,
  parameter int INIT_STRIDE = 16,
  parameter int ZERO_R0     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     flags_en,
  input  logic [3:0]               flags_in,
  input  logic                     rd_en,
  input  logic [$clog2(NREGS)-1:0] rd_addr1,
  input  logic [$clog2(NREGS)-1:0] rd_addr2,
  input  logic                     imm_or_reg,
  input  logic [7:0]               imm,
  input  logic [3:0]               sft_imm,
  input  logic [7:0]               sft_ctl,
  input  logic [$clog2(NREGS)-1:0] show_sel,
  output logic [DW-1:0]            opr1,
  output logic [DW-1:0]            opr2,
  output logic                     opr_valid,
  output logic [1:0]               fwd_hit,
  output logic [3:0]               flags_out,
  output logic [SHOW_W-1:0]        show
);

  localparam int c_AW    = $clog2(NREGS);
  localparam int c_SW    = $clog2(DW);
  localparam int c_AMT_W = max_int(c_SW, 5);

  logic [DW-1:0]     r_regs [NREGS];
  logic [DW-1:0]     r_opr1;
  logic [DW-1:0]     r_opr2;
  logic              r_valid;
  logic [1:0]        r_hit;
  logic [3:0]        r_flags;
  logic [SHOW_W-1:0] r_show;

  logic              w_wr_ok;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_hita;
  logic [DW-1:0]     w_eff1;
  logic [DW-1:0]     w_eff2;
  logic [c_AW-1:0]   w_amt_addr;
  logic [c_SW-1:0]   w_amt_reg;
  logic [c_AMT_W-1:0] w_amt;
  sft_op_e           w_op;
  logic [DW-1:0]     w_imm_sh;
  logic [DW-1:0]     w_reg_sh;

  function automatic logic is_r0(input logic [c_AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  assign w_wr_ok    = wr_en && !is_r0(wr_addr);
  assign w_amt_addr = c_AW'(sft_ctl[7:4]);
  assign w_op       = sft_op_e'(sft_ctl[2:1]);

  // Every read port sees this cycle's write-back; the hardwired zero register never bypasses.
  always_comb begin
    w_hit1 = wr_en && (wr_addr == rd_addr1) && !is_r0(rd_addr1);
    w_hit2 = wr_en && (wr_addr == rd_addr2) && !is_r0(rd_addr2);
    w_hita = wr_en && (wr_addr == w_amt_addr) && !is_r0(w_amt_addr);

    w_eff1 = is_r0(rd_addr1) ? '0 : (w_hit1 ? wr_data : r_regs[rd_addr1]);
    w_eff2 = is_r0(rd_addr2) ? '0 : (w_hit2 ? wr_data : r_regs[rd_addr2]);

    w_amt_reg = is_r0(w_amt_addr) ? '0
              : (w_hita ? wr_data[c_SW-1:0] : r_regs[w_amt_addr][c_SW-1:0]);
    w_amt     = sft_ctl[0] ? c_AMT_W'(w_amt_reg) : c_AMT_W'(sft_ctl[7:3]);
  end

  opr2_shifter #(
    .DW    (DW),
    .AMT_W (c_AMT_W)
  ) u_imm_rot (
    .value  (DW'(imm)),
    .amt    (c_AMT_W'({sft_imm, 1'b0})),
    .op     (SFT_ROR),
    .result (w_imm_sh)
  );

  opr2_shifter #(
    .DW    (DW),
    .AMT_W (c_AMT_W)
  ) u_reg_sh (
    .value  (w_eff2),
    .amt    (w_amt),
    .op     (w_op),
    .result (w_reg_sh)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= (k < NREGS - 1) ? DW'(k * INIT_STRIDE) : '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_opr1  <= '0;
      r_opr2  <= '0;
      r_valid <= 1'b0;
      r_hit   <= '0;
      r_flags <= '0;
      r_show  <= '0;
    end else begin
      r_valid <= rd_en;
      if (rd_en) begin
        r_opr1 <= w_eff1;
        r_opr2 <= imm_or_reg ? w_imm_sh : w_reg_sh;
        r_hit  <= {!imm_or_reg && w_hit2, w_hit1};
      end
      if (flags_en) begin
        r_flags <= flags_in;
      end
      // Debug view deliberately lags the write port by one edge.
      r_show <= r_regs[show_sel][SHOW_W-1:0];
    end
  end

  assign opr1      = r_opr1;
  assign opr2      = r_opr2;
  assign opr_valid = r_valid;
  assign fwd_hit   = r_hit;
  assign flags_out = r_flags;
  assign show      = r_show;

endmodule : wb_regfile_param
`default_nettype wire

// File: tb/tb_wb_regfile_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wb_regfile_param                                                |
// | Table-driven, scoreboarded bench for wb_regfile_param.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_wb_regfile_param;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flags_en;
  logic [3:0]  flags_in;
  logic        rd_en;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic        imm_or_reg;
  logic [7:0]  imm;
  logic [3:0]  sft_imm;
  logic [7:0]  sft_ctl;
  logic [3:0]  show_sel;
  logic [31:0] opr1;
  logic [31:0] opr2;
  logic        opr_valid;
  logic [1:0]  fwd_hit;
  logic [3:0]  flags_out;
  logic [15:0] show;

  wb_regfile_param #(
    .DW          (32),
    .NREGS       (16),
    .SHOW_W      (16),
    .INIT_STRIDE (16),
    .ZERO_R0     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flags_en   (flags_en),
    .flags_in   (flags_in),
    .rd_en      (rd_en),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .imm_or_reg (imm_or_reg),
    .imm        (imm),
    .sft_imm    (sft_imm),
    .sft_ctl    (sft_ctl),
    .show_sel   (show_sel),
    .opr1       (opr1),
    .opr2       (opr2),
    .opr_valid  (opr_valid),
    .fwd_hit    (fwd_hit),
    .flags_out  (flags_out),
    .show       (show)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o1;
    logic [31:0] o2;
    logic [1:0]  hit;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic        ior;
    logic [7:0]  im;
    logic [3:0]  si;
    logic [7:0]  sc;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [1:0]  eh;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] o1, input logic [31:0] o2, input logic [1:0] hit);
    exp_t e;
    e.o1 = o1;
    e.o2 = o2;
    e.hit = hit;
    sb.push_back(e);
  endtask

  // One clock: a fetch issued before the edge is scored right after it.
  task automatic tick();
    logic exp_v;
    exp_t e;
    exp_v = rd_en && rst;
    @(posedge clk);
    #1;
    check("opr_valid", 64'(opr_valid), 64'(exp_v));
    if (exp_v) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("opr1", 64'(opr1), 64'(e.o1));
        check("opr2", 64'(opr2), 64'(e.o2));
        check("fwd_hit", 64'(fwd_hit), 64'(e.hit));
      end
    end
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    flags_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 4'd0, 32'h0,        4'd1,  4'd0, 1'b1, 8'hFF, 4'd4, 8'h00, 32'h10,       32'hFF000000, 2'b00};
    vecs[1]  = '{1'b0, 4'd0, 32'h0,        4'd15, 4'd0, 1'b1, 8'h3C, 4'd0, 8'h00, 32'h0,        32'h0000003C, 2'b00};
    vecs[2]  = '{1'b0, 4'd0, 32'h0,        4'd2,  4'd0, 1'b1, 8'h81, 4'd1, 8'h00, 32'h20,       32'h40000020, 2'b00};
    vecs[3]  = '{1'b1, 4'd2, 32'h80000000, 4'd2,  4'd2, 1'b0, 8'h00, 4'd0, 8'h24, 32'h80000000, 32'hF8000000, 2'b11};
    vecs[4]  = '{1'b1, 4'd2, 32'h0000000F, 4'd5,  4'd2, 1'b0, 8'h00, 4'd0, 8'h26, 32'h50,       32'hF0000000, 2'b10};
    vecs[5]  = '{1'b0, 4'd0, 32'h0,        4'd2,  4'd2, 1'b0, 8'h00, 4'd0, 8'h22, 32'h0F,       32'h000000F0, 2'b00};
    vecs[6]  = '{1'b0, 4'd0, 32'h0,        4'd4,  4'd3, 1'b0, 8'h00, 4'd0, 8'h20, 32'h40,       32'h0DEADBEE, 2'b00};
    vecs[7]  = '{1'b0, 4'd0, 32'h0,        4'd3,  4'd3, 1'b0, 8'h00, 4'd0, 8'h04, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vecs[8]  = '{1'b0, 4'd0, 32'h0,        4'd3,  4'd3, 1'b0, 8'h00, 4'd0, 8'hFC, 32'hDEADBEEF, 32'hFFFFFFFF, 2'b00};
    vecs[9]  = '{1'b0, 4'd0, 32'h0,        4'd6,  4'd3, 1'b0, 8'h00, 4'd0, 8'h86, 32'h60,       32'hBEEFDEAD, 2'b00};
    vecs[10] = '{1'b1, 4'd4, 32'h23,       4'd4,  4'd3, 1'b0, 8'h00, 4'd0, 8'h00, 32'h23,       32'hDEADBEEF, 2'b01};
    vecs[11] = '{1'b1, 4'd2, 32'h1,        4'd0,  4'd2, 1'b0, 8'h00, 4'd0, 8'h43, 32'h0,        32'h00000008, 2'b10};
    vecs[12] = '{1'b1, 4'd4, 32'h2,        4'd4,  4'd2, 1'b0, 8'h00, 4'd0, 8'h43, 32'h2,        32'h00000004, 2'b01};
    vecs[13] = '{1'b1, 4'd0, 32'hFFFF,     4'd0,  4'd0, 1'b0, 8'h00, 4'd0, 8'h00, 32'h0,        32'h0,        2'b00};
    vecs[14] = '{1'b0, 4'd0, 32'h0,        4'd2,  4'd2, 1'b0, 8'h00, 4'd0, 8'h03, 32'h1,        32'h00000001, 2'b00};

    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; flags_en = 1'b0; flags_in = '0;
    rd_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0; imm_or_reg = 1'b0; imm = '0; sft_imm = '0;
    sft_ctl = '0; show_sel = '0;

    // Reset state
    tick();
    rst = 1'b1;
    check("reset_flags", 64'(flags_out), 64'h0);
    show_sel = 4'd5; tick();
    check("show_r5_reset", 64'(show), 64'h0050);
    show_sel = 4'd15; tick();
    check("show_r15_reset", 64'(show), 64'h0);

    // Write and fetch of the same register on one edge
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
    rd_en = 1'b1; rd_addr1 = 4'd3; rd_addr2 = 4'd3; imm_or_reg = 1'b0; sft_ctl = 8'h00;
    show_sel = 4'd3;
    push(32'hDEADBEEF, 32'hDEADBEEF, 2'b11);
    tick();
    check("show_pre_write", 64'(show), 64'h0030);
    idle(); tick();
    check("show_post_write", 64'(show), 64'hBEEF);

    // Hardwired zero register
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h1234;
    rd_en = 1'b1; rd_addr1 = 4'd0; rd_addr2 = 4'd0; show_sel = 4'd0;
    push(32'h0, 32'h0, 2'b00);
    tick();
    idle(); tick();
    check("show_r0", 64'(show), 64'h0);

    for (int i = 0; i < 15; i++) begin
      wr_en = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = 1'b1; rd_addr1 = vecs[i].a1; rd_addr2 = vecs[i].a2;
      imm_or_reg = vecs[i].ior; imm = vecs[i].im; sft_imm = vecs[i].si; sft_ctl = vecs[i].sc;
      push(vecs[i].e1, vecs[i].e2, vecs[i].eh);
      tick();
    end

    // Operands hold while no fetch is requested
    idle(); rd_addr1 = 4'd3; tick();
    check("hold_opr1", 64'(opr1), 64'h1);
    check("hold_opr2", 64'(opr2), 64'h1);
    check("hold_fwd", 64'(fwd_hit), 64'h0);

    flags_en = 1'b1; flags_in = 4'hA; show_sel = 4'd4; tick();
    check("flags_set", 64'(flags_out), 64'hA);
    check("show_r4", 64'(show), 64'h0002);
    flags_en = 1'b0; flags_in = 4'h5; tick();
    check("flags_hold", 64'(flags_out), 64'hA);

    // Reset collides with write, fetch and flag update
    rst = 1'b0; wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'hAAAA;
    rd_en = 1'b1; rd_addr1 = 4'd6; flags_en = 1'b1; flags_in = 4'hF;
    tick();
    check("rst_flags", 64'(flags_out), 64'h0);
    check("rst_opr1", 64'(opr1), 64'h0);
    check("rst_opr2", 64'(opr2), 64'h0);
    check("rst_fwd", 64'(fwd_hit), 64'h0);
    check("rst_show", 64'(show), 64'h0);
    rst = 1'b1; idle(); show_sel = 4'd6; tick();
    check("show_r6_after_rst", 64'(show), 64'h0060);
    show_sel = 4'd4; tick();
    check("show_r4_after_rst", 64'(show), 64'h0040);
    show_sel = 4'd2; tick();
    check("show_r2_after_rst", 64'(show), 64'h0020);

    rd_en = 1'b1; rd_addr1 = 4'd3; rd_addr2 = 4'd7; imm_or_reg = 1'b0; sft_ctl = 8'h22;
    push(32'h30, 32'h700, 2'b00);
    tick();
    idle(); tick();

    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_wb_regfile_param
`default_nettype wire
